// File: rtl/pulp_soc_tcdm_pkg.sv
// Shared TCDM definitions for the L2 bank port: bus widths and the packed
// request/response payloads that travel between requesters and a bank.
package pulp_soc_tcdm_pkg;

    localparam int TCDM_ADDR_WIDTH = 32;
    localparam int TCDM_DATA_WIDTH = 32;
    localparam int TCDM_BE_WIDTH   = 4;

    typedef struct packed {
        logic                       wen;
        logic [TCDM_BE_WIDTH-1:0]   be;
        logic [TCDM_ADDR_WIDTH-1:0] add;
        logic [TCDM_DATA_WIDTH-1:0] wdata;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DATA_WIDTH-1:0] rdata;
        logic                       opc;
    } tcdm_resp_t;

endpackage

// File: rtl/tcdm_bank_arbiter_if.sv
// TCDM bundle with N request lanes and a broadcast response; the master side
// issues requests, the slave side grants them and returns responses.
interface tcdm_bank_arbiter_if #(parameter int N = 1);
    import pulp_soc_tcdm_pkg::*;

    logic [N-1:0]                            req;
    logic [N-1:0][TCDM_ADDR_WIDTH-1:0]       add;
    logic [N-1:0]                            wen;
    logic [N-1:0][TCDM_BE_WIDTH-1:0]         be;
    logic [N-1:0][TCDM_DATA_WIDTH-1:0]       wdata;
    logic [N-1:0]                            gnt;
    logic [N-1:0]                            r_valid;
    logic [TCDM_DATA_WIDTH-1:0]              r_rdata;
    logic                                    r_opc;

    modport master (
        output req, add, wen, be, wdata,
        input  gnt, r_valid, r_rdata, r_opc
    );

    modport slave (
        input  req, add, wen, be, wdata,
        output gnt, r_valid, r_rdata, r_opc
    );

endinterface

// File: rtl/tcdm_bank_arbiter_rr_prio_select.sv
// Round-robin priority search: returns the first active requester at or above
// rr_ptr, wrapping around to index 0.
module rr_prio_select #(
    parameter  int NR_REQ   = 4,
    localparam int ID_WIDTH = $clog2(NR_REQ)
) (
    input  logic [NR_REQ-1:0]   req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [ID_WIDTH-1:0] winner,
    output logic                valid
);

    localparam int DW = 2 * NR_REQ;

    logic [NR_REQ-1:0] mask;
    logic [NR_REQ-1:0] masked;
    logic [DW-1:0]     doubled;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            mask[i] = (i >= int'(rr_ptr));
        end
    end

    // The lower half only holds requesters at or above the pointer, so the
    // lowest set bit of the doubled vector is the wrapped round-robin winner.
    assign masked  = req & mask;
    assign doubled = {req, masked};

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (doubled[i]) begin
                valid  = 1'b1;
                winner = (i >= NR_REQ) ? ID_WIDTH'(i - NR_REQ) : ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank among NR_REQ requesters, with a
// fixed-latency tracker that routes each bank response back to its issuer.
module tcdm_bank_arbiter
    import pulp_soc_tcdm_pkg::*;
#(
    parameter  int NR_REQ   = 4,
    parameter  int RESP_LAT = 1,
    localparam int ID_WIDTH = $clog2(NR_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tcdm_bank_arbiter_if.slave   req_port,
    tcdm_bank_arbiter_if.master  bank_port
);

    tcdm_req_t                           req_fields [NR_REQ];
    tcdm_req_t                           win_fields;
    tcdm_resp_t                          bank_resp;
    logic [ID_WIDTH-1:0]                 rr_ptr;
    logic [ID_WIDTH-1:0]                 winner;
    logic                                any_req;
    logic                                bank_req;
    logic                                handshake;
    logic [RESP_LAT-1:0]                 sr_valid;
    logic [RESP_LAT-1:0][ID_WIDTH-1:0]   sr_id;
    logic                                valid_out;
    logic [ID_WIDTH-1:0]                 id_out;

    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            req_fields[i].wen   = req_port.wen[i];
            req_fields[i].be    = req_port.be[i];
            req_fields[i].add   = req_port.add[i];
            req_fields[i].wdata = req_port.wdata[i];
        end
    end

    rr_prio_select #(.NR_REQ(NR_REQ)) u_select (
        .req    (req_port.req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (any_req)
    );

    assign bank_req  = any_req & ~rst_i;
    assign handshake = bank_req & bank_port.gnt[0];

    always_comb begin
        win_fields = '0;
        if (any_req) begin
            win_fields = req_fields[winner];
        end
    end

    assign bank_port.req[0]   = bank_req;
    assign bank_port.add[0]   = win_fields.add;
    assign bank_port.wen[0]   = win_fields.wen;
    assign bank_port.be[0]    = win_fields.be;
    assign bank_port.wdata[0] = win_fields.wdata;

    always_comb begin
        req_port.gnt         = '0;
        req_port.gnt[winner] = handshake;
    end

    // Pointer only moves on a handshake so a stalled winner keeps its turn.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == ID_WIDTH'(NR_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_valid <= '0;
        end else begin
            sr_valid[0] <= handshake;
            for (int i = 1; i < RESP_LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        sr_id[0] <= winner;
        for (int i = 1; i < RESP_LAT; i++) begin
            sr_id[i] <= sr_id[i-1];
        end
    end

    assign valid_out = sr_valid[RESP_LAT-1];
    assign id_out    = sr_id[RESP_LAT-1];

    assign bank_resp.rdata = bank_port.r_rdata;
    assign bank_resp.opc   = bank_port.r_opc;

    always_comb begin
        req_port.r_valid = '0;
        req_port.r_valid[id_out] = bank_port.r_valid[0] & valid_out & ~rst_i;
    end

    assign req_port.r_rdata = bank_resp.rdata;
    assign req_port.r_opc   = bank_resp.opc;

    // Bank must answer exactly RESP_LAT cycles after every grant, never otherwise.
    resp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        bank_port.r_valid[0] |-> valid_out);

    resp_dropped: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_out |-> bank_port.r_valid[0]);

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Checks two arbiter instances (response latency 1 and 3) fed identical
// requester traffic against a cycle-level round-robin and latency model.
module tb_tcdm_bank_arbiter;
    import pulp_soc_tcdm_pkg::*;

    localparam int NR   = 4;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tcdm_bank_arbiter_if #(.N(NR)) req_if_a ();
    tcdm_bank_arbiter_if #(.N(1))  bank_if_a ();
    tcdm_bank_arbiter_if #(.N(NR)) req_if_b ();
    tcdm_bank_arbiter_if #(.N(1))  bank_if_b ();

    tcdm_bank_arbiter #(.NR_REQ(NR), .RESP_LAT(1)) dut_a (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_port  (req_if_a),
        .bank_port (bank_if_a)
    );

    tcdm_bank_arbiter #(.NR_REQ(NR), .RESP_LAT(3)) dut_b (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_port  (req_if_b),
        .bank_port (bank_if_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ptr      = 0;

    bit             hs       [MAXC];
    int             hs_id    [MAXC];
    bit             rst_hist [MAXC];
    logic [NR-1:0]  last_gnt;

    logic [31:0]    f_add [NR];
    logic [31:0]    f_wd  [NR];
    logic [3:0]     f_be  [NR];
    logic [NR-1:0]  f_wen;

    logic [NR-1:0]  exp_gnt;
    logic           exp_breq;
    logic [31:0]    exp_add;
    logic           exp_wen;
    logic [3:0]     exp_be;
    logic [31:0]    exp_wd;

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", tag, cyc, actual, expected);
        end
    endtask

    task automatic check_inst(input string n, input logic r,
                              input logic [NR-1:0] g, input logic breq,
                              input logic [31:0] badd, input logic bwen,
                              input logic [3:0] bbe, input logic [31:0] bwd,
                              input logic [NR-1:0] rv, input logic [31:0] rdo,
                              input logic opo, input logic [NR-1:0] erv,
                              input logic [31:0] erd, input logic eop);
        check_output({n, ".gnt"},      64'(g),    64'(exp_gnt));
        check_output({n, ".bank_req"}, 64'(breq), 64'(exp_breq));
        check_output({n, ".r_valid"},  64'(rv),   64'(erv));
        check_output({n, ".r_rdata"},  64'(rdo),  64'(erd));
        check_output({n, ".r_opc"},    64'(opo),  64'(eop));
        if (!r) begin
            check_output({n, ".bank_add"},   64'(badd), 64'(exp_add));
            check_output({n, ".bank_wen"},   64'(bwen), 64'(exp_wen));
            check_output({n, ".bank_be"},    64'(bbe),  64'(exp_be));
            check_output({n, ".bank_wdata"}, 64'(bwd),  64'(exp_wd));
        end
    endtask

    // One clock cycle: drive requesters and both banks, predict, compare, advance model.
    task automatic apply_stimulus(input bit r, input logic [NR-1:0] req, input bit bgnt);
        bit            any;
        int            winner;
        int            lat;
        bit            alive [2];
        logic [31:0]   rd    [2];
        logic          op    [2];
        logic [NR-1:0] erv   [2];

        @(posedge clk);
        #1;
        rst = r;
        rst_hist[cyc] = r;
        for (int i = 0; i < NR; i++) begin
            f_add[i] = $urandom;
            f_wd[i]  = $urandom;
            f_be[i]  = 4'($urandom);
        end
        f_wen = NR'($urandom);
        req_if_a.req = req;
        req_if_b.req = req;
        req_if_a.wen = f_wen;
        req_if_b.wen = f_wen;
        for (int i = 0; i < NR; i++) begin
            req_if_a.add[i]   = f_add[i];
            req_if_b.add[i]   = f_add[i];
            req_if_a.be[i]    = f_be[i];
            req_if_b.be[i]    = f_be[i];
            req_if_a.wdata[i] = f_wd[i];
            req_if_b.wdata[i] = f_wd[i];
        end
        bank_if_a.gnt[0] = bgnt;
        bank_if_b.gnt[0] = bgnt;

        // A response is alive if its grant happened lat cycles ago and no reset came in between.
        for (int k = 0; k < 2; k++) begin
            lat      = (k == 0) ? 1 : 3;
            alive[k] = 1'b0;
            erv[k]   = '0;
            if (cyc >= lat && hs[cyc-lat]) begin
                alive[k] = 1'b1;
                for (int j = cyc - lat + 1; j < cyc; j++) begin
                    if (rst_hist[j]) alive[k] = 1'b0;
                end
                if (alive[k] && !r) erv[k] = NR'(1) << hs_id[cyc-lat];
            end
            rd[k] = $urandom;
            op[k] = 1'($urandom);
        end
        bank_if_a.r_valid[0] = alive[0];
        bank_if_a.r_rdata    = rd[0];
        bank_if_a.r_opc      = op[0];
        bank_if_b.r_valid[0] = alive[1];
        bank_if_b.r_rdata    = rd[1];
        bank_if_b.r_opc      = op[1];

        any    = |req;
        winner = 0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (req[(ptr + k) % NR]) winner = (ptr + k) % NR;
        end
        exp_breq = any && !r;
        exp_gnt  = (exp_breq && bgnt) ? (NR'(1) << winner) : '0;
        exp_add  = any ? f_add[winner] : '0;
        exp_wen  = any ? f_wen[winner] : 1'b0;
        exp_be   = any ? f_be[winner]  : '0;
        exp_wd   = any ? f_wd[winner]  : '0;

        @(negedge clk);
        check_inst("lat1", r, req_if_a.gnt, bank_if_a.req[0], bank_if_a.add[0],
                   bank_if_a.wen[0], bank_if_a.be[0], bank_if_a.wdata[0],
                   req_if_a.r_valid, req_if_a.r_rdata, req_if_a.r_opc,
                   erv[0], rd[0], op[0]);
        check_inst("lat3", r, req_if_b.gnt, bank_if_b.req[0], bank_if_b.add[0],
                   bank_if_b.wen[0], bank_if_b.be[0], bank_if_b.wdata[0],
                   req_if_b.r_valid, req_if_b.r_rdata, req_if_b.r_opc,
                   erv[1], rd[1], op[1]);
        last_gnt = req_if_a.gnt;

        hs[cyc]    = exp_breq && bgnt;
        hs_id[cyc] = winner;
        if (r)            ptr = 0;
        else if (hs[cyc]) ptr = (winner + 1) % NR;
        cyc++;
    endtask

    initial begin
        logic [NR-1:0] rr_order [5];
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1;
        req_if_a.req = '0;  req_if_b.req = '0;
        req_if_a.add = '0;  req_if_b.add = '0;
        req_if_a.wen = '0;  req_if_b.wen = '0;
        req_if_a.be = '0;   req_if_b.be = '0;
        req_if_a.wdata = '0; req_if_b.wdata = '0;
        bank_if_a.gnt = '0; bank_if_b.gnt = '0;
        bank_if_a.r_valid = '0; bank_if_b.r_valid = '0;
        bank_if_a.r_rdata = '0; bank_if_b.r_rdata = '0;
        bank_if_a.r_opc = 1'b0; bank_if_b.r_opc = 1'b0;

        apply_stimulus(1'b1, 4'b0000, 1'b0);
        apply_stimulus(1'b1, 4'b1111, 1'b1);

        // Single requester, immediate grant.
        apply_stimulus(1'b0, 4'b0100, 1'b1);
        check_output("single_gnt", 64'(last_gnt), 64'(4'b0100));
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);

        // All requesting from a freshly reset pointer: 0,1,2,3 then wrap.
        apply_stimulus(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 4'b1111, 1'b1);
            check_output("rr_order", 64'(last_gnt), 64'(rr_order[i]));
        end
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Bank stall keeps the pointer.
        apply_stimulus(1'b1, 4'b0000, 1'b0);
        repeat (3) begin
            apply_stimulus(1'b0, 4'b0011, 1'b0);
            check_output("stall_gnt", 64'(last_gnt), 64'(4'b0000));
        end
        apply_stimulus(1'b0, 4'b0011, 1'b1);
        check_output("after_stall_gnt", 64'(last_gnt), 64'(4'b0001));
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Back-to-back requests from ids 1 and 2.
        apply_stimulus(1'b0, 4'b0010, 1'b1);
        apply_stimulus(1'b0, 4'b0100, 1'b1);
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Reset right after a grant to id 3.
        apply_stimulus(1'b0, 4'b1000, 1'b1);
        apply_stimulus(1'b1, 4'b0000, 1'b0);
        apply_stimulus(1'b0, 4'b0110, 1'b1);
        check_output("post_reset_gnt", 64'(last_gnt), 64'(4'b0010));
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            apply_stimulus($urandom_range(63) == 0, NR'($urandom),
                           $urandom_range(3) != 0);
        end
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit TCDM bank port (one output of the interleaved L2 crossbar) between NR_REQ requesters.
- Multiplexes the request channel and returns each response to the requester that issued it.
- Tracks in-flight requests over a fixed bank response latency.
- Sits between the crossbar slave-side outputs plus any side masters (e.g. debug, DMA) and a single L2 bank.

Parameters:
- NR_REQ, 4: number of requesters; must be at least 2; not required to be a power of two.
- RESP_LAT, 1: cycles from the bank grant handshake to the bank response (r_valid_i); must be at least 1.
- ID_WIDTH, $clog2(NR_REQ): width of the requester index; localparam.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous, active-high reset.
- req_i, in, NR_REQ: per-requester request.
- add_i, in, NR_REQ x 32: byte address.
- wen_i, in, NR_REQ: 1 = read, 0 = write (TCDM polarity).
- be_i, in, NR_REQ x 4: byte enables.
- wdata_i, in, NR_REQ x 32: write data.
- gnt_o, out, NR_REQ: grant, one-hot or zero.
- r_valid_o, out, NR_REQ: response valid, one-hot or zero.
- r_rdata_o, out, 32: response data, broadcast to all requesters.
- r_opc_o, out, 1: response error flag, broadcast to all requesters.
- bank_req_o, out, 1: request to the bank.
- bank_add_o, out, 32: address to the bank.
- bank_wen_o, out, 1: read/write to the bank.
- bank_be_o, out, 4: byte enables to the bank.
- bank_wdata_o, out, 32: write data to the bank.
- bank_gnt_i, in, 1: bank grant.
- bank_r_valid_i, in, 1: bank response valid.
- bank_r_rdata_i, in, 32: bank response data.
- bank_r_opc_i, in, 1: bank response error flag.

Behaviour:
- Arbitration (combinational):
  - Winner = first requester with req_i high, searching from rr_ptr upward with wrap NR_REQ-1 -> 0.
  - bank_req_o = |req_i. Bank request fields are the winner's fields; when no requester is active, all fields are 0.
  - gnt_o[winner] = bank_gnt_i & bank_req_o; all other gnt_o bits are 0.
- Request holding: a requester holds req_i and its fields stable until it sees gnt_o. The arbiter does not check this.
- Pointer:
  - On a handshake (bank_req_o & bank_gnt_i), rr_ptr <= winner+1, wrapping NR_REQ-1 -> 0.
  - With no handshake, rr_ptr holds, so a requester that loses keeps its priority position.
- Response tracking:
  - RESP_LAT-deep shift register of {valid, id}.
  - Stage 0 loads {handshake, winner} every cycle; the register shifts unconditionally.
  - Both reads and writes produce a response.
- Response routing:
  - r_valid_o[id_out] = bank_r_valid_i & valid_out; all other bits are 0.
  - r_rdata_o = bank_r_rdata_i and r_opc_o = bank_r_opc_i, passed through unchanged.
- Throughput: one request per cycle; back-to-back grants to the same requester are allowed only when no other requester is active.
- Protocol errors:
  - bank_r_valid_i while valid_out = 0: no r_valid_o is asserted. Sticky-free assertion in simulation only.
  - valid_out = 1 without bank_r_valid_i: the entry is dropped and a simulation assertion fires.
- Reset (rst_i = 1, sampled at the clock edge):
  - rr_ptr <= 0; all shift-register valid bits <= 0.
  - gnt_o and bank_req_o are forced to 0 while rst_i is high.
  - r_valid_o = 0 while rst_i is high.
  - In-flight responses are dropped on reset mid-operation.
- Reset values of outputs:
  - gnt_o, r_valid_o, bank_req_o = 0.
  - All data outputs = 0 when no requester is active.
- Simultaneous events: a new handshake and a response for an older one in the same cycle are independent; both are handled.

Decomposition:
- Shared package pulp_soc_tcdm_pkg:
  - TCDM_ADDR_WIDTH = 32, TCDM_DATA_WIDTH = 32, TCDM_BE_WIDTH = 4.
  - Packed struct tcdm_req_t {wen, be, add, wdata}.
  - Packed struct tcdm_resp_t {rdata, opc}.
- One sub-module, rr_prio_select:
  - Parametric NR_REQ, combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: winner index and valid.
  - Double-width mask trick for the wrapped priority search.

Test Plan:
- Single requester, RESP_LAT = 1: req_i = 4'b0100, read of 0x1C00_0010, bank_gnt_i = 1 -> gnt_o = 4'b0100 in the same cycle; next cycle r_valid_o = 4'b0100 with rdata 0xDEADBEEF.
- All four requesting, bank_gnt_i held at 1: grants in order 0, 1, 2, 3, 0 on consecutive cycles; rr_ptr wraps to 0 after index 3.
- Bank stall: req_i = 4'b0011, bank_gnt_i = 0 for 3 cycles then 1 -> gnt_o = 0 during the stall, then 4'b0001; rr_ptr stays 0 during the stall.
- RESP_LAT = 3, interleaved writes from ids 1 and 2 on back-to-back cycles -> r_valid_o = 4'b0010 then 4'b0100, three cycles after each respective grant.
- Reset mid-flight: grant id 3 at cycle t, rst_i high at t+1 -> no r_valid_o ever asserts for id 3; rr_ptr = 0 after reset; first post-reset grant goes to the lowest active requester.
- Error response: bank_r_opc_i = 1 on the response to id 0 -> r_opc_o = 1 with r_valid_o = 4'b0001.
